tdm_nco_bank: RTL and testbench
===============================

# tdm_nco_bank

Parametrised time-division-multiplexed NCO bank: the next generation of the per-voice channel manager, feeding wavetable BRAM addresses and channel IDs to the sample pipeline. It holds VOICES phase accumulators, each with its own increment and enable. On each sample tick it sweeps all voices once, one slot per clock, and emits a registered address/channel stream. It adds a frame-level state machine, per-voice enables, overrun detection and an optional dithered phase truncation.

## Interface
- VOICES, 8: number of voices (power of two, 2..32)
- VOICE_BITS, 3: log2(VOICES)
- PHASE_W, 24: phase accumulator width
- INC_W, 16: increment width, zero-extended to PHASE_W
- ADDR_W, 8: wavetable address width (≤ PHASE_W)
- sys_clk  in  1  single clock; all logic on rising edge
- sys_rst_n  in  1  synchronous, active-low reset
- tick  in  1  start-of-frame request, one-cycle pulse
- cfg_we  in  1  config write strobe
- cfg_voice  in  VOICE_BITS  target voice
- cfg_inc  in  INC_W  new increment
- cfg_en  in  1  new enable for target voice
- addr_out  out  ADDR_W  wavetable address
- chan_out  out  VOICE_BITS  voice ID for addr_out
- valid_out  out  1  addr_out/chan_out valid
- mute_out  out  1  voice of this slot disabled
- frame_done  out  1  pulse on last slot of a frame
- busy  out  1  frame in progress
- overrun  out  1  sticky: tick arrived while busy

## Operation
- Storage: inc[VOICES], en[VOICES], phase[VOICES] in flops.
- States: IDLE, SCAN. IDLE→SCAN on tick; slot counter s=0. SCAN: one voice per cycle, s increments; after s=VOICES-1 → IDLE.
- Per slot s: output old phase[s] truncated to its top ADDR_W bits. If en[s], then phase[s] ← (phase[s] + inc[s]) mod 2^PHASE_W. If !en[s], then phase[s] ← 0, mute_out=1, addr_out=0.
- Slots always sweep 0..VOICES-1 in order. Disabled voices still occupy a slot (valid_out=1) to keep TDM alignment.
- Config write: inc[cfg_voice] ← cfg_inc, en[cfg_voice] ← cfg_en, at the clock edge. Accepted in any state, every cycle; no backpressure.
- Same-cycle write and slot on the same voice: the slot uses the pre-write inc/en. New values apply from the next frame.
- tick while busy: ignored; overrun ← 1. It is cleared only by reset.
- tick on the same cycle as the final SCAN slot counts as busy and triggers overrun.

## Timing
- Reset values: all outputs 0; all phase/inc/en 0; state IDLE.
- tick at edge t → busy=1 from t+1. Slot k is computed in cycle t+1+k; outputs are registered and valid in cycle t+2+k.
- Frame latency: first valid VOICES... first valid output 2 cycles after tick, last valid VOICES+1 cycles after tick. frame_done coincides with the valid of slot VOICES-1.
- busy falls in the cycle after the last slot is computed. The earliest accepted next tick is the cycle busy reads 0.
- valid_out is low outside frames; addr_out/chan_out hold their last values.
- Reset asserted mid-frame: the next edge forces reset values and aborts the frame. No frame_done is issued.
- Phase wrap is silent modulo 2^PHASE_W, with no flag.

## Configuration
- TDM_NCO_DITHER_EN defined: a 16-bit Fibonacci LFSR is included.
  - Polynomial x^16+x^14+x^13+x^11+1, reset seed 0xACE1.
  - It advances once per enabled slot.
  - Its low (PHASE_W-ADDR_W) bits are added to the phase before truncation; the address wraps modulo 2^ADDR_W. The stored phase is unaffected.
- Undefined: plain truncation, no LFSR logic.

## Structure
- synth_pkg holds the defaults for VOICES/PHASE_W/ADDR_W, the state encoding (IDLE=0, SCAN=1), and the LFSR seed/taps constants.
- Sub-module lfsr16 (enable, synchronous active-low reset, 16-bit state out) is instantiated only under TDM_NCO_DITHER_EN.

## Test plan
- Reset then tick, no config → 8 valid slots, chan_out 0..7, all mute_out=1, addr_out=0, frame_done on chan 7, valid 2 cycles after tick.
- Voice 3 inc=0x0100 (en=1), PHASE_W=24, ADDR_W=8, 256 ticks → voice 3 addr_out on frame n = (n·0x100)>>16, i.e. 0 for n<256 then wraps. Also set inc=0xFFFF and confirm the address steps every frame and wraps 0xFF→0x00 with no glitch in other channels.
- tick repeated 3 cycles after the first → overrun=1 stays high, frame still completes 8 slots, no second frame.
- cfg_we to voice 2 in the exact cycle slot 2 computes → current frame uses the old inc, next frame the new inc.
- Reset pulse during slot 4 → valid_out=0 next cycle, no frame_done, phases 0, overrun 0. A following tick restarts from slot 0.
- With TDM_NCO_DITHER_EN, inc=0 on voice 0 with phase 0x00FF00 → addr_out alternates 0x00/0x01 per LFSR sequence from seed 0xACE1. Without it, constant 0x00.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared defaults, FSM encoding and LFSR constants for the TDM NCO bank.
package synth_pkg;

   localparam int DEF_VOICES     = 8;
   localparam int DEF_VOICE_BITS = 3;
   localparam int DEF_PHASE_W    = 24;
   localparam int DEF_INC_W      = 16;
   localparam int DEF_ADDR_W     = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

   // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right: feedback taps at bits 0,2,3,5
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/tdm_nco_bank_if.sv
// Tick/config/slot-stream bundle between the NCO bank and its neighbours.
interface tdm_nco_bank_if #(
   parameter int VOICE_BITS = synth_pkg::DEF_VOICE_BITS,
   parameter int INC_W      = synth_pkg::DEF_INC_W,
   parameter int ADDR_W     = synth_pkg::DEF_ADDR_W
);
   logic                  tick;
   logic                  cfg_we;
   logic [VOICE_BITS-1:0] cfg_voice;
   logic [INC_W-1:0]      cfg_inc;
   logic                  cfg_en;
   logic [ADDR_W-1:0]     addr_out;
   logic [VOICE_BITS-1:0] chan_out;
   logic                  valid_out;
   logic                  mute_out;
   logic                  frame_done;
   logic                  busy;
   logic                  overrun;

   modport master (
      output tick, cfg_we, cfg_voice, cfg_inc, cfg_en,
      input  addr_out, chan_out, valid_out, mute_out, frame_done, busy, overrun
   );

   modport slave (
      input  tick, cfg_we, cfg_voice, cfg_inc, cfg_en,
      output addr_out, chan_out, valid_out, mute_out, frame_done, busy, overrun
   );
endinterface

// File: rtl/tdm_nco_bank_lfsr16.sv
// 16-bit Fibonacci LFSR used as the phase-truncation dither source.
module lfsr16
   import synth_pkg::*;
(
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        enable,
   output logic [15:0] state
);

   logic feedback;

   assign feedback = ^(state & LFSR_TAPS);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state <= LFSR_SEED;
      end else if (enable) begin
         state <= {feedback, state[15:1]};
      end
   end

endmodule

// File: rtl/tdm_nco_bank.sv
// Time-division-multiplexed NCO bank: one voice per clock per frame, registered address stream.
// Optional dithered truncation is built when TDM_NCO_DITHER_EN is defined.
module tdm_nco_bank
   import synth_pkg::*;
#(
   parameter int VOICES     = DEF_VOICES,
   parameter int VOICE_BITS = DEF_VOICE_BITS,
   parameter int PHASE_W    = DEF_PHASE_W,
   parameter int INC_W      = DEF_INC_W,
   parameter int ADDR_W     = DEF_ADDR_W
) (
   input logic           sys_clk,
   input logic           sys_rst_n,
   tdm_nco_bank_if.slave bus
);

   localparam int FRAC_W = PHASE_W - ADDR_W;
   localparam logic [VOICE_BITS-1:0] LAST_SLOT = VOICE_BITS'(VOICES - 1);

   scan_state_t           state_q, state_d;
   logic [VOICE_BITS-1:0] slot_q, slot_d;
   logic                  slot_fire;
   logic                  slot_last;

   logic [INC_W-1:0]      inc_q   [VOICES];
   logic [PHASE_W-1:0]    phase_q [VOICES];
   logic [VOICES-1:0]     en_q;

   logic [PHASE_W-1:0]    cur_phase;
   logic [INC_W-1:0]      cur_inc;
   logic                  cur_en;
   logic [PHASE_W-1:0]    next_phase;
   logic [PHASE_W-1:0]    dithered_phase;
   logic [ADDR_W-1:0]     addr_calc;

   logic [ADDR_W-1:0]     addr_q;
   logic [VOICE_BITS-1:0] chan_q;
   logic                  valid_q;
   logic                  mute_q;
   logic                  done_q;
   logic                  overrun_q;

   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      slot_fire = 1'b0;
      slot_last = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.tick) begin
               state_d = SCAN;
               slot_d  = '0;
            end
         end
         SCAN: begin
            slot_fire = 1'b1;
            if (slot_q == LAST_SLOT) begin
               state_d   = IDLE;
               slot_last = 1'b1;
            end else begin
               slot_d = slot_q + VOICE_BITS'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         slot_q  <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
      end
   end

   // The slot reads pre-edge storage, so a same-cycle config write only lands for the next frame.
   always_comb begin
      cur_phase  = phase_q[slot_q];
      cur_inc    = inc_q[slot_q];
      cur_en     = en_q[slot_q];
      next_phase = cur_en ? (cur_phase + PHASE_W'(cur_inc)) : '0;
   end

`ifdef TDM_NCO_DITHER_EN
   localparam logic [PHASE_W-1:0] FRAC_MASK = (PHASE_W'(1) << FRAC_W) - PHASE_W'(1);

   logic [15:0] lfsr_state;

   lfsr16 u_lfsr (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .enable    (slot_fire & cur_en),
      .state     (lfsr_state)
   );

   assign dithered_phase = cur_phase + (PHASE_W'(lfsr_state) & FRAC_MASK);
`else
   assign dithered_phase = cur_phase;
`endif

   assign addr_calc = ADDR_W'(dithered_phase >> FRAC_W);

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         for (int v = 0; v < VOICES; v++) begin
            phase_q[v] <= '0;
            inc_q[v]   <= '0;
         end
         en_q <= '0;
      end else begin
         if (slot_fire) begin
            phase_q[slot_q] <= next_phase;
         end
         if (bus.cfg_we) begin
            inc_q[bus.cfg_voice] <= bus.cfg_inc;
            en_q[bus.cfg_voice]  <= bus.cfg_en;
         end
      end
   end

   // Address and channel hold between frames; the qualifiers drop back to 0.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         addr_q    <= '0;
         chan_q    <= '0;
         valid_q   <= 1'b0;
         mute_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         valid_q <= slot_fire;
         mute_q  <= slot_fire & ~cur_en;
         done_q  <= slot_last;
         if (slot_fire) begin
            addr_q <= cur_en ? addr_calc : '0;
            chan_q <= slot_q;
         end
         if (bus.tick && (state_q == SCAN)) begin
            overrun_q <= 1'b1;
         end
      end
   end

   assign bus.addr_out   = addr_q;
   assign bus.chan_out   = chan_q;
   assign bus.valid_out  = valid_q;
   assign bus.mute_out   = mute_q;
   assign bus.frame_done = done_q;
   assign bus.busy       = (state_q == SCAN);
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_tdm_nco_bank.sv
// Self-checking bench for tdm_nco_bank: frame-level reference model plus directed literal checks.
module tb_tdm_nco_bank;
   import synth_pkg::*;

   localparam int V  = 8;
   localparam int VB = 3;
   localparam int PW = 24;
   localparam int IW = 16;
   localparam int AW = 8;

   typedef struct {
      int         e;
      int         chan;
      logic [7:0] addr;
      logic       mute;
      logic       last;
   } slot_t;

   logic sys_clk = 1'b0;
   logic sys_rst_n;

   always #5 sys_clk = ~sys_clk;

   tdm_nco_bank_if #(.VOICE_BITS(VB), .INC_W(IW), .ADDR_W(AW)) bus ();

   tdm_nco_bank #(
      .VOICES(V), .VOICE_BITS(VB), .PHASE_W(PW), .INC_W(IW), .ADDR_W(AW)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus.slave)
   );

   int n_vec  = 0;
   int n_miss = 0;

   slot_t       exp_q[$];
   logic [15:0] inc_m   [V];
   logic        en_m    [V];
   logic [23:0] phase_m [V];
   logic [15:0] lfsr_m = LFSR_SEED;
   int          edge_n = 0;
   int          frame_left = 0;
   logic        ov_m = 1'b0;

   int          vcnt   = 0;
   int          fd_cnt = 0;
   int          fcount = 0;
   logic [7:0]  obs [V][1024];

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_vec++;
      if (act !== exp_v) begin
         n_miss++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
      end
   endtask

`ifdef TDM_NCO_DITHER_EN
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic b;
      b = s[0] ^ s[2] ^ s[3] ^ s[5];
      return {b, s[15:1]};
   endfunction
`endif

   // Reference model: a whole frame is predicted when its tick is accepted.
   always @(posedge sys_clk) begin
      slot_t       x;
      logic [23:0] p;
      edge_n++;
      if (!sys_rst_n) begin
         exp_q.delete();
         for (int v = 0; v < V; v++) begin
            inc_m[v] = '0; en_m[v] = 1'b0; phase_m[v] = '0;
         end
         lfsr_m = LFSR_SEED;
         frame_left = 0;
         ov_m = 1'b0;
      end else begin
         if (bus.tick && frame_left == 0) begin
            for (int v = 0; v < V; v++) begin
               x.e = edge_n + 1 + v;
               x.chan = v;
               x.last = (v == V - 1);
               if (en_m[v]) begin
                  p = phase_m[v];
`ifdef TDM_NCO_DITHER_EN
                  p = p + {8'h00, lfsr_m};
                  lfsr_m = lfsr_next(lfsr_m);
`endif
                  x.addr = p[23:16];
                  x.mute = 1'b0;
                  phase_m[v] = phase_m[v] + {8'h00, inc_m[v]};
               end else begin
                  x.addr = 8'h00;
                  x.mute = 1'b1;
                  phase_m[v] = '0;
               end
               exp_q.push_back(x);
            end
            frame_left = V;
         end else if (frame_left > 0) begin
            if (bus.tick) ov_m = 1'b1;
            frame_left--;
         end
         if (bus.cfg_we) begin
            inc_m[bus.cfg_voice] = bus.cfg_inc;
            en_m[bus.cfg_voice]  = bus.cfg_en;
         end
      end
   end

   always @(negedge sys_clk) begin
      slot_t x;
      if (exp_q.size() > 0 && exp_q[0].e == edge_n) begin
         x = exp_q.pop_front();
         check_output("valid_out", 32'(bus.valid_out), 32'd1);
         check_output("chan_out", 32'(bus.chan_out), 32'(x.chan));
         check_output("addr_out", 32'(bus.addr_out), 32'(x.addr));
         check_output("mute_out", 32'(bus.mute_out), 32'(x.mute));
         check_output("frame_done", 32'(bus.frame_done), 32'(x.last));
      end else begin
         check_output("valid_idle", 32'(bus.valid_out), 32'd0);
         check_output("frame_done_idle", 32'(bus.frame_done), 32'd0);
      end
      check_output("busy", 32'(bus.busy), 32'(frame_left > 0));
      check_output("overrun", 32'(bus.overrun), 32'(ov_m));
      if (bus.valid_out === 1'b1) begin
         vcnt++;
         if (fcount < 1024) obs[bus.chan_out][fcount] = bus.addr_out;
      end
      if (bus.frame_done === 1'b1) begin
         fd_cnt++;
         fcount++;
      end
   end

   task automatic apply_stimulus(input logic t, input logic we, input int voice, input int inc_v, input logic e);
      bus.tick      = t;
      bus.cfg_we    = we;
      bus.cfg_voice = voice[2:0];
      bus.cfg_inc   = inc_v[15:0];
      bus.cfg_en    = e;
      @(posedge sys_clk);
      #1;
      bus.tick   = 1'b0;
      bus.cfg_we = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) apply_stimulus(1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic run_frame();
      apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
      idle(V + 1);
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      idle(1);
      sys_rst_n = 1'b1;
   endtask

   initial begin
      int base, c0, f0;
      bus.tick = 1'b0; bus.cfg_we = 1'b0; bus.cfg_voice = '0; bus.cfg_inc = '0; bus.cfg_en = 1'b0;
      sys_rst_n = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      check_output("rst_valid", 32'(bus.valid_out), 32'd0);
      check_output("rst_addr", 32'(bus.addr_out), 32'd0);
      check_output("rst_chan", 32'(bus.chan_out), 32'd0);
      check_output("rst_mute", 32'(bus.mute_out), 32'd0);
      check_output("rst_done", 32'(bus.frame_done), 32'd0);
      check_output("rst_busy", 32'(bus.busy), 32'd0);
      check_output("rst_overrun", 32'(bus.overrun), 32'd0);
      sys_rst_n = 1'b1;

      // Unconfigured frame: 8 muted slots, first valid two cycles after tick
      apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
      check_output("busy_after_tick", 32'(bus.busy), 32'd1);
      check_output("no_valid_1_after_tick", 32'(bus.valid_out), 32'd0);
      idle(1);
      check_output("first_valid", 32'(bus.valid_out), 32'd1);
      check_output("first_chan", 32'(bus.chan_out), 32'd0);
      check_output("first_mute", 32'(bus.mute_out), 32'd1);
      idle(7);
      check_output("last_chan", 32'(bus.chan_out), 32'd7);
      check_output("last_done", 32'(bus.frame_done), 32'd1);
      check_output("last_addr", 32'(bus.addr_out), 32'd0);
      idle(1);
      check_output("post_frame_valid", 32'(bus.valid_out), 32'd0);
      check_output("post_frame_busy", 32'(bus.busy), 32'd0);

      // Long run: slow voice 3 and near-full-scale voice 5 with wrap
      do_reset();
      apply_stimulus(1'b0, 1'b1, 3, 16'h0100, 1'b1);
      apply_stimulus(1'b0, 1'b1, 5, 16'hFFFF, 1'b1);
      base = fcount;
      repeat (258) run_frame();
`ifndef TDM_NCO_DITHER_EN
      check_output("v3_frame255", 32'(obs[3][base + 255]), 32'h00);
      check_output("v3_frame256", 32'(obs[3][base + 256]), 32'h01);
      check_output("v5_frame1", 32'(obs[5][base + 1]), 32'h00);
      check_output("v5_frame2", 32'(obs[5][base + 2]), 32'h01);
      check_output("v5_frame256", 32'(obs[5][base + 256]), 32'hFF);
      check_output("v5_frame257", 32'(obs[5][base + 257]), 32'h00);
`endif

      // Second tick three cycles into a frame
      do_reset();
      c0 = vcnt;
      f0 = fd_cnt;
      apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
      idle(2);
      apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
      check_output("overrun_set", 32'(bus.overrun), 32'd1);
      idle(V + 2);
      check_output("overrun_sticky", 32'(bus.overrun), 32'd1);
      check_output("overrun_slots", 32'(vcnt - c0), 32'd8);
      check_output("overrun_frames", 32'(fd_cnt - f0), 32'd1);

      // Config write to voice 2 in the cycle slot 2 is computed
      do_reset();
      apply_stimulus(1'b0, 1'b1, 2, 16'hFFFF, 1'b1);
      base = fcount;
      apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
      idle(2);
      apply_stimulus(1'b0, 1'b1, 2, 16'h0001, 1'b1);
      idle(6);
      run_frame();
      run_frame();
      check_output("v2_frame2_new_inc", 32'(obs[2][base + 2]), 32'h01);
`ifndef TDM_NCO_DITHER_EN
      check_output("v2_frame1", 32'(obs[2][base + 1]), 32'h00);
`endif

      // Reset during slot 4 aborts the frame
      do_reset();
      apply_stimulus(1'b0, 1'b1, 1, 16'hFFFF, 1'b1);
      repeat (3) run_frame();
      f0 = fd_cnt;
      apply_stimulus(1'b1, 1'b0, 0, 0, 1'b0);
      idle(4);
      sys_rst_n = 1'b0;
      idle(1);
      sys_rst_n = 1'b1;
      check_output("abort_valid", 32'(bus.valid_out), 32'd0);
      check_output("abort_done", 32'(bus.frame_done), 32'd0);
      check_output("abort_busy", 32'(bus.busy), 32'd0);
      check_output("abort_overrun", 32'(bus.overrun), 32'd0);
      check_output("abort_addr", 32'(bus.addr_out), 32'd0);
      idle(V + 2);
      check_output("abort_no_frame_done", 32'(fd_cnt - f0), 32'd0);
      apply_stimulus(1'b0, 1'b1, 1, 0, 1'b1);
      base = fcount;
      run_frame();
      check_output("abort_phase_cleared", 32'(obs[1][base]), 32'h00);

      // Voice 0 parked at phase 0x00FF00 with zero increment
      do_reset();
      apply_stimulus(1'b0, 1'b1, 0, 16'hFF00, 1'b1);
      run_frame();
      apply_stimulus(1'b0, 1'b1, 0, 0, 1'b1);
      base = fcount;
      repeat (3) run_frame();
`ifndef TDM_NCO_DITHER_EN
      for (int i = 0; i < 3; i++) begin
         check_output("plain_truncation", 32'(obs[0][base + i]), 32'h00);
      end
`endif

      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #1000000;
      n_miss++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
